// File: rtl/decim_pkg.sv
// ---------------------------------------------------------------------------
// decim_pkg
// Shared types and defaults for the boxcar decimator.
//   sample_t        : signed 32-bit sample type used on both sides of the block
//   ACC_W_DEFAULT   : default accumulator width (>= 39 to hold 128 full-scale
//                     32-bit samples without wrapping)
//   DEPTH_DEFAULT   : default output FIFO depth in entries
//   MAX_LOG2_RATIO  : largest supported log2 decimation ratio (N = 128)
// ---------------------------------------------------------------------------
package decim_pkg;

    typedef logic signed [31:0] sample_t;

    localparam int ACC_W_DEFAULT  = 40;
    localparam int DEPTH_DEFAULT  = 4;
    localparam int MAX_LOG2_RATIO = 7;

endpackage

// File: rtl/decim_fifo.sv
// ---------------------------------------------------------------------------
// decim_fifo
// Small show-ahead FIFO with a registered head value.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   i_push       : write request for i_data
//   i_pop        : consume the current head entry
//   i_data       : entry to write
//   o_head       : head entry, driven straight from a register
//   o_full       : DEPTH entries held
//   o_empty      : no entries held
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is ignored (the caller flags the drop). A newly written entry
// becomes visible at o_head on the cycle after the push.
// ---------------------------------------------------------------------------
module decim_fifo
    import decim_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    i_push,
    input  logic    i_pop,
    input  sample_t i_data,
    output sample_t o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sample_t            r_mem [DEPTH];
    sample_t            r_head;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic [PTR_W-1:0]   w_rd_next;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    assign w_push_ok = i_push && (!w_full || w_pop_ok);
    assign w_rd_next = r_rd_ptr + PTR_W'(1);

    // Storage array carries no reset; validity is tracked by r_count.
    always_ff @(posedge clock) begin
        if (!reset && w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Keep r_head equal to the entry at the read pointer. When the
            // only stored entry is popped, the next head is whatever is being
            // pushed in the same cycle (it is not in r_mem yet).
            if (w_empty) begin
                if (w_push_ok) begin
                    r_head <= i_data;
                end
            end else if (w_pop_ok) begin
                if (r_count == CNT_W'(1)) begin
                    if (w_push_ok) begin
                        r_head <= i_data;
                    end
                end else begin
                    r_head <= r_mem[w_rd_next];
                end
            end
        end
    end

    assign o_head  = r_head;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/boxcar_decimator.sv
// ---------------------------------------------------------------------------
// boxcar_decimator
// Sums N = 2^ratio consecutive valid samples and emits the floor average
// into an output FIFO.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   io_in_value/valid   : input sample stream, no backpressure
//   io_log2_ratio       : log2 of the decimation ratio, latched at window start
//   io_out_value/valid  : FIFO head and not-empty flag
//   io_out_ready        : consumer accepts the head this cycle
//   io_overflow         : sticky, a result was dropped on a full FIFO
//   io_overflow_clear   : clears io_overflow (a same-cycle drop wins)
// Handshake: an output entry transfers on every rising edge where
// io_out_valid and io_out_ready are both high; io_out_value is stable while
// io_out_valid is high and io_out_ready is low.
// ---------------------------------------------------------------------------
module boxcar_decimator
    import decim_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] io_in_value,
    input  logic        io_in_valid,
    input  logic [2:0]  io_log2_ratio,
    output logic [31:0] io_out_value,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic        io_overflow,
    input  logic        io_overflow_clear
);

    if (ACC_W < 39) begin : g_bad_acc_w
        $error("boxcar_decimator: ACC_W must be at least 39");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("boxcar_decimator: DEPTH must be a power of two >= 2");
    end

    logic signed [ACC_W-1:0] r_acc;
    logic [7:0]              r_count;
    logic [2:0]              r_ratio;
    logic                    r_overflow;

    logic [2:0]              w_ratio;
    logic [7:0]              w_n;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_dump;
    sample_t                 w_result;
    sample_t                 w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_drop;

    // The first sample of a window uses the live ratio input; later samples
    // use the value latched with that first sample.
    assign w_ratio  = (r_count == 8'd0) ? io_log2_ratio : r_ratio;
    assign w_n      = 8'd1 << w_ratio;
    assign w_sum    = r_acc + {{(ACC_W-32){io_in_value[31]}}, io_in_value};
    assign w_dump   = io_in_valid && ((r_count + 8'd1) == w_n);
    assign w_result = sample_t'(w_sum >>> w_ratio);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ratio <= '0;
        end else if (io_in_valid) begin
            if (r_count == 8'd0) begin
                r_ratio <= io_log2_ratio;
            end
            if (w_dump) begin
                r_acc   <= '0;
                r_count <= '0;
            end else begin
                r_acc   <= w_sum;
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign w_pop  = !w_empty && io_out_ready;
    assign w_drop = w_dump && w_full && !w_pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (io_overflow_clear) begin
            r_overflow <= 1'b0;
        end
    end

    decim_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_dump),
        .i_pop   (w_pop),
        .i_data  (w_result),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign io_out_value = w_head;
    assign io_out_valid = !w_empty;
    assign io_overflow  = r_overflow;

endmodule

// File: doc/boxcar_decimator.md
BOXCAR_DECIMATOR -- requirements
Module: boxcar_decimator

Interface
REQ-001 Parameter DEPTH, default 4: output FIFO depth in entries, power of two, minimum 2.
REQ-002 Parameter ACC_W, default 40: accumulator width in bits; the block SHALL require ACC_W >= 39.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_in_value  input  32  signed two's-complement sample from the upstream FIR stage.
REQ-006 io_in_valid  input  1  io_in_value is a new sample this cycle; there is no backpressure on the input.
REQ-007 io_log2_ratio  input  3  decimation ratio N = 2^io_log2_ratio, giving N from 1 to 128.
REQ-008 io_out_value  output  32  signed decimated sample at the FIFO head.
REQ-009 io_out_valid  output  1  FIFO is not empty.
REQ-010 io_out_ready  input  1  consumer accepts the head entry when io_out_valid is also high.
REQ-011 io_overflow  output  1  sticky flag: a result was dropped because the FIFO was full.
REQ-012 io_overflow_clear  input  1  clears io_overflow.

Function
REQ-013 Accumulator: on each cycle with io_in_valid high, the block SHALL add the sign-extended io_in_value to the ACC_W-bit accumulator and increment the window counter.
REQ-014 Ratio latch: the block SHALL capture io_log2_ratio only when the window counter is 0 and io_in_valid is high; ratio changes mid-window SHALL NOT affect the current window.
REQ-015 Dump: on the accepted sample that makes the count equal N, the result SHALL be (accumulator + sample) arithmetically shifted right by the latched log2 ratio (floor rounding), truncated to 32 bits.
REQ-016 On the dump cycle, the accumulator and counter SHALL restart from 0, so the next sample opens a new window with no lost cycles.
REQ-017 When N = 1, every valid input SHALL produce a result equal to that input.
REQ-018 Latency: a result computed on cycle t SHALL be written to the FIFO at the edge ending cycle t; io_out_valid SHALL be high in cycle t+1 if the FIFO was empty.
REQ-019 FIFO: the FIFO SHALL pop when io_out_valid and io_out_ready are both high.
REQ-020 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-021 Simultaneous push and pop on an empty FIFO SHALL NOT occur, because the new entry is not yet visible.
REQ-022 Full drop: a push to a full FIFO with no pop in the same cycle SHALL drop the new result, leave the FIFO contents unchanged, and set io_overflow on the next cycle.
REQ-023 io_overflow_clear SHALL clear io_overflow; if a drop and a clear occur in the same cycle, the set SHALL win.
REQ-024 io_out_value SHALL be driven from the FIFO head register, with no combinational path from io_in_value.
REQ-025 io_out_value SHALL hold steady while io_out_valid is high and io_out_ready is low.

Reset
REQ-026 Reset SHALL be synchronous and active-high.
REQ-027 On reset, the accumulator, window counter and latched ratio SHALL be 0, and the FIFO SHALL be empty.
REQ-028 On reset, io_out_valid = 0, io_out_value = 0 and io_overflow = 0.
REQ-029 Reset asserted mid-window SHALL discard the partial sum, and no output SHALL be produced for that window.
REQ-030 Reset SHALL take priority over io_in_valid, pushes and pops in the same cycle.

Structure
REQ-031 Package decim_pkg SHALL hold: typedef sample_t (signed 32-bit), the ACC_W and DEPTH defaults, and MAX_LOG2_RATIO = 7.
REQ-032 The FIFO SHALL be a separate sub-module, decim_fifo, with push/pop/full/empty ports and a registered head.
REQ-033 The accumulate-and-dump datapath SHALL remain in boxcar_decimator.

Verification
REQ-034 Steady stream: log2_ratio=2, input 1000 valid every cycle, out_ready=1 -> output 1000 every 4th cycle; the first io_out_valid comes one cycle after the 4th sample.
REQ-035 Pass-through: log2_ratio=0, inputs -5, 7, 0x7FFFFFFF -> the same three values, each one cycle later.
REQ-036 Floor rounding and gaps: log2_ratio=1, inputs 3 then -4 with io_in_valid gapped by 2 idle cycles -> single output 0xFFFFFFFF (-1).
REQ-037 Full FIFO: log2_ratio=0, out_ready=0, six inputs 1..6 -> io_overflow set after the 5th input; raising out_ready then drains 1, 2, 3, 4; pulsing io_overflow_clear clears the flag.
REQ-038 Reset mid-window and ratio change: log2_ratio=3, 5 samples of 10, then a 1-cycle reset, then log2_ratio changed to 1 mid-window after 1 sample -> no output from the first window.
REQ-039 Ratio-change follow-up (continuing REQ-038): the second window still completes at 8 samples; the following window uses N=2.
REQ-040 Extremes: log2_ratio=7, 128 samples of 0x7FFFFFFF -> 0x7FFFFFFF; 128 samples of 0x80000000 -> 0x80000000; the accumulator does not wrap.
